irda_f_int_ctrl: RTL and testbench

- Interrupt controller/arbiter for the fast-IR (FIR) path.
- Collects seven event sources from the RX/TX FIFOs and the framer, latches pulse events, and applies the f_ier enable mask.
- Selects the highest-priority pending source and drives the f_iir register value and the int_o line.
- Clears latched events on an IIR read strobe. Contains the RX FIFO character-timeout counter.

---
 rtl/irda_f_int_ctrl.sv | 157 +++++++++++++++
 tb/tb_irda_f_int_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irda_f_int_ctrl.sv
// FIR interrupt controller: latches pulse events, masks with f_ier, prioritises into f_iir/int_o,
// and owns the RX FIFO character-timeout counter.
module irda_f_int_ctrl #(
    parameter int unsigned TIMEOUT_W     = 8,
    parameter int unsigned TIMEOUT_LIMIT = 64
) (
    input  logic       clk,
    input  logic       wb_rst_i,
    input  logic [6:0] f_ier,
    input  logic       f_iir_read,
    input  logic       en,
    input  logic       rx_thresh,
    input  logic       tx_thresh,
    input  logic       rx_frame_end,
    input  logic       tx_frame_done,
    input  logic       rx_error,
    input  logic       rx_overrun,
    input  logic       rx_fifo_empty,
    input  logic       rx_fifo_pop,
    input  logic       rx_active,
    input  logic       rx_fifo_reset,
    input  logic       tx_fifo_reset,
    output logic [7:0] f_iir,
    output logic       int_o,
    output logic [6:0] pending_o
);

    typedef enum logic [1:0] {StIdle, StCount, StExpired} tmo_state_e;

    localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT_LIMIT - 1);
    localparam logic [TIMEOUT_W-1:0] CntOne  = TIMEOUT_W'(1);

    tmo_state_e           tmo_q, tmo_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 tmo_set;

    logic [6:2] sticky_q, sticky_d, set_v, clr_v;
    logic [6:0] pending, masked;
    logic [2:0] id;
    logic [7:0] f_iir_q, f_iir_d, iir_prev_q;
    logic       int_q;

    // Timeout counter: fires once per FIFO-idle episode, then waits for a pop/empty/reset.
    always_comb begin
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        tmo_set = 1'b0;
        if (rx_fifo_reset) begin
            tmo_d = StIdle;
            cnt_d = '0;
        end else begin
            unique case (tmo_q)
                StIdle: begin
                    cnt_d = '0;
                    if (!rx_fifo_empty && !rx_active) begin
                        tmo_d = StCount;
                    end
                end
                StCount: begin
                    if (rx_fifo_empty) begin
                        tmo_d = StIdle;
                        cnt_d = '0;
                    end else if (rx_fifo_pop || rx_active) begin
                        cnt_d = '0;
                    end else if (en) begin
                        if (cnt_q == CntLast) begin
                            tmo_set = 1'b1;
                            tmo_d   = StExpired;
                        end else begin
                            cnt_d = cnt_q + CntOne;
                        end
                    end
                end
                StExpired: begin
                    if (rx_fifo_pop || rx_fifo_empty) begin
                        tmo_d = StIdle;
                        cnt_d = '0;
                    end
                end
                default: begin
                    tmo_d = StIdle;
                    cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            tmo_q <= StIdle;
            cnt_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            cnt_q <= cnt_d;
        end
    end

    // Read-clear targets the id the bus actually sampled, held in iir_prev_q.
    always_comb begin
        set_v = {tmo_set, rx_overrun, rx_error, tx_frame_done, rx_frame_end};
        clr_v = '0;
        if (f_iir_read && !iir_prev_q[0] && (iir_prev_q[3:1] >= 3'd2)
            && (iir_prev_q[3:1] <= 3'd6)) begin
            clr_v[iir_prev_q[3:1]] = 1'b1;
        end
        if (rx_fifo_reset) begin
            clr_v = clr_v | 5'b11101;
        end
        if (tx_fifo_reset) begin
            clr_v[3] = 1'b1;
        end
        sticky_d = (sticky_q & ~clr_v) | set_v;
    end

    assign pending   = {sticky_q, tx_thresh, rx_thresh};
    assign masked    = pending & f_ier;
    assign pending_o = pending;

    // Priority order: 4, 5, 2, 6, 0, 3, 1.
    always_comb begin
        id = 3'd0;
        if (masked[4]) begin
            id = 3'd4;
        end else if (masked[5]) begin
            id = 3'd5;
        end else if (masked[2]) begin
            id = 3'd2;
        end else if (masked[6]) begin
            id = 3'd6;
        end else if (masked[0]) begin
            id = 3'd0;
        end else if (masked[3]) begin
            id = 3'd3;
        end else if (masked[1]) begin
            id = 3'd1;
        end
        f_iir_d = {4'h0, id, ~|masked};
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sticky_q   <= '0;
            f_iir_q    <= 8'h01;
            iir_prev_q <= 8'h01;
            int_q      <= 1'b0;
        end else begin
            sticky_q   <= sticky_d;
            f_iir_q    <= f_iir_d;
            iir_prev_q <= f_iir_q;
            int_q      <= |masked;
        end
    end

    assign f_iir = f_iir_q;
    assign int_o = int_q;

endmodule

// File: tb/tb_irda_f_int_ctrl.sv
// Bench for irda_f_int_ctrl: directed vector table, hand sequences for reset/timeout,
// then randomized traffic against a behavioural model.
module tb_irda_f_int_ctrl;

    localparam int unsigned Lim = 4;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic [6:0] f_ier;
    logic       f_iir_read, en;
    logic       rx_thresh, tx_thresh, rx_frame_end, tx_frame_done, rx_error, rx_overrun;
    logic       rx_fifo_empty, rx_fifo_pop, rx_active, rx_fifo_reset, tx_fifo_reset;
    logic [7:0] f_iir;
    logic       int_o;
    logic [6:0] pending_o;

    int checks = 0;
    int errors = 0;

    irda_f_int_ctrl #(
        .TIMEOUT_W    (8),
        .TIMEOUT_LIMIT(Lim)
    ) dut (
        .clk          (clk),
        .wb_rst_i     (wb_rst_i),
        .f_ier        (f_ier),
        .f_iir_read   (f_iir_read),
        .en           (en),
        .rx_thresh    (rx_thresh),
        .tx_thresh    (tx_thresh),
        .rx_frame_end (rx_frame_end),
        .tx_frame_done(tx_frame_done),
        .rx_error     (rx_error),
        .rx_overrun   (rx_overrun),
        .rx_fifo_empty(rx_fifo_empty),
        .rx_fifo_pop  (rx_fifo_pop),
        .rx_active    (rx_active),
        .rx_fifo_reset(rx_fifo_reset),
        .tx_fifo_reset(tx_fifo_reset),
        .f_iir        (f_iir),
        .int_o        (int_o),
        .pending_o    (pending_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] ier;
        logic [5:0] src;   // {overrun, error, tx_done, rx_end, tx_thresh, rx_thresh}
        logic       rd;
        logic       rxrst;
        logic       txrst;
        logic [7:0] iir;
        logic       intr;
        logic [6:0] pend;
    } vec_t;

    vec_t tv[31];

    // Behavioural model state
    logic [6:0] m_sticky;
    logic [7:0] m_iir, m_prev;
    logic       m_int;
    int         m_mode;    // 0 idle, 1 counting, 2 expired
    int         m_cnt;
    int         prio[7] = '{4, 5, 2, 6, 0, 3, 1};

    function automatic vec_t mk(logic [6:0] ier, logic [5:0] src, logic rd, logic rxrst,
                                logic txrst, logic [7:0] iir, logic intr, logic [6:0] pend);
        vec_t v;
        v.ier = ier; v.src = src; v.rd = rd; v.rxrst = rxrst; v.txrst = txrst;
        v.iir = iir; v.intr = intr; v.pend = pend;
        return v;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        f_iir_read = 0; en = 0; rx_thresh = 0; tx_thresh = 0; rx_frame_end = 0;
        tx_frame_done = 0; rx_error = 0; rx_overrun = 0; rx_fifo_pop = 0; rx_active = 0;
        rx_fifo_reset = 0; tx_fifo_reset = 0;
    endtask

    task automatic step(logic en_v, logic pop_v, logic rd_v);
        @(negedge clk);
        en = en_v; rx_fifo_pop = pop_v; f_iir_read = rd_v;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_sticky = '0; m_iir = 8'h01; m_prev = 8'h01; m_int = 0; m_mode = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic [6:0] pend, masked, clr, setv;
        logic [7:0] niir;
        logic       set6, found;
        pend   = {m_sticky[6:2], tx_thresh, rx_thresh};
        masked = pend & f_ier;
        niir   = 8'h01;
        found  = 0;
        for (int k = 0; k < 7; k++) begin
            if (!found && masked[prio[k]]) begin
                niir  = {4'h0, 3'(prio[k]), 1'b0};
                found = 1;
            end
        end
        set6 = 0;
        if (rx_fifo_reset) begin
            m_mode = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            if (!rx_fifo_empty && !rx_active) begin m_mode = 1; m_cnt = 0; end
        end else if (m_mode == 1) begin
            if (rx_fifo_empty) begin m_mode = 0; m_cnt = 0; end
            else if (rx_fifo_pop || rx_active) m_cnt = 0;
            else if (en) begin
                m_cnt++;
                if (m_cnt == Lim) begin set6 = 1; m_mode = 2; end
            end
        end else if (rx_fifo_pop || rx_fifo_empty) begin
            m_mode = 0; m_cnt = 0;
        end
        clr = '0;
        if (f_iir_read && !m_prev[0] && m_prev[3:1] >= 3'd2 && m_prev[3:1] <= 3'd6)
            clr[m_prev[3:1]] = 1'b1;
        if (rx_fifo_reset) clr = clr | 7'b1110100;
        if (tx_fifo_reset) clr[3] = 1'b1;
        setv = {set6, rx_overrun, rx_error, tx_frame_done, rx_frame_end, 2'b00};
        m_sticky = ((m_sticky & ~clr) | setv) & 7'h7C;
        m_prev = m_iir;
        m_iir  = niir;
        m_int  = |masked;
    endtask

    initial begin
        tv[0]  = mk(7'h7F, 6'b010100, 0, 0, 0, 8'h01, 0, 7'h14);
        tv[1]  = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h08, 1, 7'h14);
        tv[2]  = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h08, 1, 7'h14);
        tv[3]  = mk(7'h7F, 6'b000000, 1, 0, 0, 8'h08, 1, 7'h04);
        tv[4]  = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h04, 1, 7'h04);
        tv[5]  = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h04, 1, 7'h04);
        tv[6]  = mk(7'h7F, 6'b000000, 1, 0, 0, 8'h04, 1, 7'h00);
        tv[7]  = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h01, 0, 7'h00);
        tv[8]  = mk(7'h02, 6'b000010, 0, 0, 0, 8'h02, 1, 7'h02);
        tv[9]  = mk(7'h02, 6'b000010, 0, 0, 0, 8'h02, 1, 7'h02);
        tv[10] = mk(7'h02, 6'b000010, 1, 0, 0, 8'h02, 1, 7'h02);
        tv[11] = mk(7'h02, 6'b000010, 0, 0, 0, 8'h02, 1, 7'h02);
        tv[12] = mk(7'h02, 6'b000000, 0, 0, 0, 8'h01, 0, 7'h00);
        tv[13] = mk(7'h7F, 6'b100000, 0, 0, 0, 8'h01, 0, 7'h20);
        tv[14] = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h0A, 1, 7'h20);
        tv[15] = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h0A, 1, 7'h20);
        tv[16] = mk(7'h7F, 6'b100000, 1, 0, 0, 8'h0A, 1, 7'h20);
        tv[17] = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h0A, 1, 7'h20);
        tv[18] = mk(7'h7F, 6'b000000, 1, 0, 0, 8'h0A, 1, 7'h00);
        tv[19] = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h01, 0, 7'h00);
        tv[20] = mk(7'h77, 6'b001000, 0, 0, 0, 8'h01, 0, 7'h08);
        tv[21] = mk(7'h77, 6'b000000, 0, 0, 0, 8'h01, 0, 7'h08);
        tv[22] = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h06, 1, 7'h08);
        tv[23] = mk(7'h7F, 6'b000000, 0, 0, 1, 8'h06, 1, 7'h00);
        tv[24] = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h01, 0, 7'h00);
        tv[25] = mk(7'h7F, 6'b001000, 0, 0, 1, 8'h01, 0, 7'h08);
        tv[26] = mk(7'h7F, 6'b000000, 0, 0, 1, 8'h06, 1, 7'h00);
        tv[27] = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h01, 0, 7'h00);
        tv[28] = mk(7'h7F, 6'b110100, 0, 0, 0, 8'h01, 0, 7'h34);
        tv[29] = mk(7'h7F, 6'b000000, 0, 1, 0, 8'h08, 1, 7'h00);
        tv[30] = mk(7'h7F, 6'b000000, 0, 0, 0, 8'h01, 0, 7'h00);

        idle_inputs();
        f_ier = 7'h7F;
        rx_fifo_empty = 1;
        wb_rst_i = 1;
        #12;
        chk("reset_iir", f_iir, 8'h01);
        chk("reset_int", 8'(int_o), 8'h00);
        chk("reset_pend", 8'(pending_o), 8'h00);
        @(negedge clk);
        wb_rst_i = 0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            f_ier = tv[i].ier;
            {rx_overrun, rx_error, tx_frame_done, rx_frame_end, tx_thresh, rx_thresh} = tv[i].src;
            f_iir_read = tv[i].rd;
            rx_fifo_reset = tv[i].rxrst;
            tx_fifo_reset = tv[i].txrst;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_iir", i), f_iir, tv[i].iir);
            chk($sformatf("vec%0d_int", i), 8'(int_o), 8'(tv[i].intr));
            chk($sformatf("vec%0d_pend", i), 8'(pending_o), 8'(tv[i].pend));
        end
        @(negedge clk);
        idle_inputs();

        // Asynchronous reset mid-run with bits 2 and 4 pending
        @(negedge clk);
        rx_frame_end = 1; rx_error = 1;
        @(negedge clk);
        rx_frame_end = 0; rx_error = 0;
        repeat (2) @(negedge clk);
        chk("pre_rst_iir", f_iir, 8'h08);
        #2 wb_rst_i = 1;
        #1;
        chk("midrst_iir", f_iir, 8'h01);
        chk("midrst_int", 8'(int_o), 8'h00);
        chk("midrst_pend", 8'(pending_o), 8'h00);
        @(negedge clk);
        wb_rst_i = 0;

        // Timeout: four en ticks while the FIFO sits non-empty and idle
        @(negedge clk);
        rx_fifo_empty = 0;
        step(0, 0, 0);
        for (int t = 0; t < 3; t++) step(1, 0, 0);
        chk("tmo_early", 8'(pending_o), 8'h00);
        step(1, 0, 0);
        chk("tmo_fire_pend", 8'(pending_o), 8'h40);
        step(0, 0, 0);
        chk("tmo_fire_iir", f_iir, 8'h0C);
        step(0, 0, 0);
        step(0, 0, 1);
        chk("tmo_rd_clear", 8'(pending_o), 8'h00);
        for (int t = 0; t < 6; t++) step(1, 0, 0);
        chk("tmo_expired_hold", 8'(pending_o), 8'h00);
        chk("tmo_expired_iir", f_iir, 8'h01);

        // Pop at the third tick restarts the count
        @(negedge clk);
        rx_fifo_empty = 1;
        @(negedge clk);
        rx_fifo_empty = 0;
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 1, 0);
        for (int t = 0; t < 3; t++) step(1, 0, 0);
        chk("tmo_pop_restart", 8'(pending_o), 8'h00);
        step(1, 0, 0);
        chk("tmo_pop_fire", 8'(pending_o), 8'h40);
        @(negedge clk);
        idle_inputs();
        rx_fifo_empty = 1;

        // Randomized traffic against the model
        @(negedge clk);
        wb_rst_i = 1;
        @(negedge clk);
        wb_rst_i = 0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_iir", f_iir, m_iir);
            chk("rnd_int", 8'(int_o), 8'(m_int));
            chk("rnd_pend", 8'(pending_o), 8'({m_sticky[6:2], tx_thresh, rx_thresh}));
            if ((c % 16) == 0) f_ier = 7'($urandom);
            rx_thresh     = ($urandom_range(3) == 0);
            tx_thresh     = ($urandom_range(3) == 0);
            rx_frame_end  = ($urandom_range(7) == 0);
            tx_frame_done = ($urandom_range(7) == 0);
            rx_error      = ($urandom_range(7) == 0);
            rx_overrun    = ($urandom_range(7) == 0);
            f_iir_read    = ($urandom_range(3) == 0);
            en            = ($urandom_range(1) == 0);
            rx_fifo_pop   = ($urandom_range(15) == 0);
            rx_active     = ($urandom_range(7) == 0);
            rx_fifo_reset = ($urandom_range(31) == 0);
            tx_fifo_reset = ($urandom_range(31) == 0);
            if ($urandom_range(15) == 0) rx_fifo_empty = ~rx_fifo_empty;
            model_step();
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
